// File: rtl/fetch_pc_unit_pkg.sv
// fetch_pc_unit_pkg: shared defaults and state encoding for the fetch stage
package fetch_pc_unit_pkg;
  localparam int ADDR_W_DEF = 12;
  localparam int RESET_PC_DEF = 0;
  localparam int ROM_LAT = 1;
  typedef enum logic [1:0] {BOOT, RUN, HOLD, SQUASH} state_t;
endpackage

// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_unit_if: ROM, decoder and stall signals around the fetch stage
interface fetch_pc_unit_if import fetch_pc_unit_pkg::*; #(parameter int ADDR_W = ADDR_W_DEF);
  logic stall_i;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [31:0] imem_data_i;
  logic [31:0] insn_o;
  logic insn_valid_o;
  logic [4:0] opcode_o;
  logic [4:0] aluop_o;
  logic [ADDR_W-1:0] pc_o;
  logic [ADDR_W-1:0] pc_plus1_o;
  logic bne_i, blt_i, j_i, jr_i, bex_i;
  logic ne_i, lt_i, rstatus_nz_i;
  logic [16:0] imm_i;
  logic [26:0] target_i;
  logic [31:0] rd_val_i;
  modport master (
    input stall_i, imem_data_i, bne_i, blt_i, j_i, jr_i, bex_i, ne_i, lt_i, rstatus_nz_i, imm_i, target_i, rd_val_i,
    output imem_addr_o, insn_o, insn_valid_o, opcode_o, aluop_o, pc_o, pc_plus1_o
  );
  modport slave (
    output stall_i, imem_data_i, bne_i, blt_i, j_i, jr_i, bex_i, ne_i, lt_i, rstatus_nz_i, imm_i, target_i, rd_val_i,
    input imem_addr_o, insn_o, insn_valid_o, opcode_o, aluop_o, pc_o, pc_plus1_o
  );
endinterface

// File: rtl/fetch_pc_unit_next_pc_sel.sv
// fetch_pc_unit_next_pc_sel: redirect decision and target selection
module fetch_pc_unit_next_pc_sel import fetch_pc_unit_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic accept,
  input  logic bne, blt, j, jr, bex,
  input  logic ne, lt, rstatus_nz,
  input  logic [ADDR_W-1:0] pc,
  input  logic [16:0] imm,
  input  logic [26:0] target,
  input  logic [31:0] rd_val,
  output logic taken,
  output logic [ADDR_W-1:0] tgt
);
  logic [31:0] imm_x;
  logic unused_bits;
  always_comb begin
    imm_x = 32'(signed'(imm));
    taken = accept & ((bne & ne) | (blt & lt) | j | jr | (bex & rstatus_nz));
    tgt = jr ? rd_val[ADDR_W-1:0] : (j | bex) ? target[ADDR_W-1:0] : pc + ADDR_W'(1) + imm_x[ADDR_W-1:0];
  end
  assign unused_bits = ^{imm_x, rd_val, target};
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC owner driving a 1-cycle ROM, with stall hold and squashed redirects
module fetch_pc_unit import fetch_pc_unit_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int RESET_PC = RESET_PC_DEF
) (
  input logic clock,
  input logic reset_n,
  fetch_pc_unit_if.master bus
);
  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);
  state_t state, state_nxt;
  logic [ADDR_W-1:0] f, d, tgt;
  logic [31:0] hold;
  logic accept, taken, adv;
  fetch_pc_unit_next_pc_sel #(.ADDR_W(ADDR_W)) u_sel (
    .accept(accept), .bne(bus.bne_i), .blt(bus.blt_i), .j(bus.j_i), .jr(bus.jr_i), .bex(bus.bex_i),
    .ne(bus.ne_i), .lt(bus.lt_i), .rstatus_nz(bus.rstatus_nz_i), .pc(d), .imm(bus.imm_i),
    .target(bus.target_i), .rd_val(bus.rd_val_i), .taken(taken), .tgt(tgt)
  );
  assign bus.insn_valid_o = state == RUN || state == HOLD;
  assign bus.insn_o = state == HOLD ? hold : state == BOOT ? '0 : bus.imem_data_i;
  assign bus.opcode_o = bus.insn_o[31:27];
  assign bus.aluop_o = bus.insn_o[6:2];
  assign bus.imem_addr_o = f;
  assign bus.pc_o = d;
  assign bus.pc_plus1_o = d + ADDR_W'(1);
  always_comb begin
    accept = bus.insn_valid_o & ~bus.stall_i;
    adv = ~bus.insn_valid_o | ~bus.stall_i;
    state_nxt = (state == BOOT || state == SQUASH) ? RUN : bus.stall_i ? HOLD : taken ? SQUASH : RUN;
  end
  // While held, the ROM keeps re-reading F so its word is ready the cycle after release
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= BOOT;
      f <= RST_PC;
      d <= RST_PC;
      hold <= '0;
    end else begin
      state <= state_nxt;
      if (state == RUN && bus.stall_i) hold <= bus.imem_data_i;
      if (adv) begin
        d <= f;
        f <= taken ? tgt : f + ADDR_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed vectors against a synchronous ROM model
module tb_fetch_pc_unit;
  logic clock;
  logic reset_n;
  int checks = 0;
  int failures = 0;
  fetch_pc_unit_if #(.ADDR_W(12)) bus ();
  fetch_pc_unit #(.ADDR_W(12), .RESET_PC(0)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  initial clock = 1'b0;
  always #5 clock = ~clock;
  function automatic logic [31:0] rom(input logic [11:0] a);
    return {a[4:0], 15'd0, a};
  endfunction
  always @(posedge clock) bus.imem_data_i <= rom(bus.imem_addr_o);
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic clr();
    bus.bne_i = 0; bus.blt_i = 0; bus.j_i = 0; bus.jr_i = 0; bus.bex_i = 0;
    bus.ne_i = 0; bus.lt_i = 0; bus.rstatus_nz_i = 0;
    bus.imm_i = '0; bus.target_i = '0; bus.rd_val_i = '0;
  endtask
  task automatic expect_insn(input string tag, input logic [11:0] p);
    logic [11:0] p1;
    p1 = p + 12'd1;
    check({tag, "_valid"}, 32'(bus.insn_valid_o), 32'd1);
    check({tag, "_pc"}, 32'(bus.pc_o), 32'(p));
    check({tag, "_insn"}, bus.insn_o, rom(p));
    check({tag, "_pc1"}, 32'(bus.pc_plus1_o), 32'(p1));
  endtask
  task automatic expect_bubble(input string tag);
    check({tag, "_valid"}, 32'(bus.insn_valid_o), 32'd0);
  endtask
  task automatic expect_reset(input string tag);
    check({tag, "_valid"}, 32'(bus.insn_valid_o), 32'd0);
    check({tag, "_insn"}, bus.insn_o, 32'd0);
    check({tag, "_pc"}, 32'(bus.pc_o), 32'd0);
    check({tag, "_addr"}, 32'(bus.imem_addr_o), 32'd0);
    check({tag, "_pc1"}, 32'(bus.pc_plus1_o), 32'd1);
  endtask
  initial begin
    reset_n = 1'b0;
    bus.stall_i = 1'b0;
    clr();
    #3;
    expect_reset("rst");
    repeat (2) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    #1;
    expect_bubble("boot");
    tick(); expect_insn("run0", 12'd0);
    tick(); expect_insn("run1", 12'd1);
    tick(); expect_insn("run2", 12'd2); bus.stall_i = 1;
    tick(); expect_insn("hold_a", 12'd2);
    tick(); expect_insn("hold_b", 12'd2); bus.stall_i = 0;
    tick(); expect_insn("post_stall", 12'd3); bus.bne_i = 1; bus.ne_i = 1; bus.imm_i = 17'd5;
    tick(); clr(); expect_bubble("bne_bubble");
    tick(); expect_insn("bne_tgt", 12'd9); bus.bne_i = 1; bus.ne_i = 0; bus.imm_i = 17'd5;
    tick(); clr(); expect_insn("bne_nt", 12'd10); bus.jr_i = 1; bus.rd_val_i = 32'h0000_1FFF;
    tick(); clr(); expect_bubble("jr_bubble");
    tick(); expect_insn("jr_tgt", 12'hFFF);
    tick(); expect_insn("wrap", 12'h000); bus.bex_i = 1; bus.target_i = 27'd100; bus.rstatus_nz_i = 0;
    tick(); expect_insn("bex_nt", 12'd1); bus.rstatus_nz_i = 1;
    tick(); clr(); expect_bubble("bex_bubble");
    tick(); expect_insn("bex_tgt", 12'd100);
    check("opcode", 32'(bus.opcode_o), 32'd4);
    check("aluop", 32'(bus.aluop_o), 32'd25);
    bus.j_i = 1; bus.target_i = 27'd50; bus.stall_i = 1;
    tick(); expect_insn("j_stall_a", 12'd100);
    tick(); expect_insn("j_stall_b", 12'd100); bus.stall_i = 0;
    tick(); clr(); expect_bubble("j_bubble");
    tick(); expect_insn("j_tgt", 12'd50); bus.j_i = 1; bus.target_i = 27'd7;
    tick(); clr(); expect_bubble("squash");
    #2 reset_n = 1'b0;
    #1 expect_reset("mid_rst");
    @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    #1;
    expect_bubble("reboot");
    tick(); expect_insn("restart0", 12'd0);
    tick(); expect_insn("restart1", 12'd1); bus.blt_i = 1; bus.lt_i = 1; bus.imm_i = 17'h1FFFF;
    tick(); clr(); expect_bubble("loop_bubble");
    tick(); expect_insn("self_loop", 12'd1); bus.blt_i = 1; bus.lt_i = 0;
    tick(); clr(); expect_insn("blt_nt", 12'd2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch stage directly upstream of the opcode decoder.
- Owns the PC and drives a synchronous (1-cycle-latency) instruction ROM.
- Presents the fetched instruction, with opcode and ALU-op fields split out, to the decoder.
- Consumes the decoder's branch/jump strobes plus ALU compare flags to redirect fetch; each redirect costs one squashed bubble. Supports a downstream stall.

Parameters:
- ADDR_W, 12, imem word-address width; all PC arithmetic is modulo 2^ADDR_W.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- stall_i  in  1  downstream cannot accept the current instruction
- imem_addr_o  out  ADDR_W  registered fetch address F, sampled by the ROM each edge
- imem_data_i  in  32  ROM output, equals mem[address sampled at previous edge]
- insn_o  out  32  instruction at pc_o
- insn_valid_o  out  1  insn_o is a real, unsquashed instruction
- opcode_o  out  5  insn_o[31:27]
- aluop_o  out  5  insn_o[6:2]
- pc_o  out  ADDR_W  address D of insn_o
- pc_plus1_o  out  ADDR_W  D+1, used for jal writeback
- bne_i, blt_i, j_i, jr_i, bex_i  in  1 each  decoder strobes for insn_o; j_i covers both j and jal
- ne_i, lt_i  in  1 each  ALU compare flags for insn_o
- rstatus_nz_i  in  1  $rstatus != 0
- imm_i  in  17  sign-extended branch offset N
- target_i  in  27  jump target T
- rd_val_i  in  32  $rd value for jr

Behaviour:
Reset:
- While reset_n=0, immediately: state=BOOT, F=RESET_PC, D=RESET_PC, insn_valid_o=0, insn_o=0, hold register=0.
- A reset asserted mid-operation discards in-flight fetch and stall state.

Per-cycle terms:
- accept = insn_valid_o & ~stall_i.
- taken = accept & ((bne_i&ne_i) | (blt_i&lt_i) | j_i | jr_i | (bex_i&rstatus_nz_i)).
- Target priority: jr_i (rd_val_i[ADDR_W-1:0]) > j_i (target_i[ADDR_W-1:0]) > bex_i (target_i[ADDR_W-1:0]) > branch (D+1+imm_i, truncated to ADDR_W).
- Strobes are ignored when accept=0.

States:
- BOOT: insn_valid_o=0. Next: RUN, D<=F, F<=F+1.
- RUN: insn_o=imem_data_i, insn_valid_o=1.
  - If stall_i: go to HOLD, capture hold<=imem_data_i; D and F unchanged.
  - Else if taken: go to SQUASH, D<=F, F<=target.
  - Else: stay in RUN, D<=F, F<=F+1.
- HOLD: insn_o=hold, insn_valid_o=1; the ROM keeps re-sampling F.
  - If stall_i: stay in HOLD.
  - Else: evaluate taken exactly as in RUN (same D/F updates), then go to RUN or SQUASH.
- SQUASH: insn_valid_o=0 (ROM output is the wrong-path word). stall_i and strobes are ignored. Next: RUN, D<=F, F<=F+1.

Timing and boundaries:
- Latency: address issued in cycle n appears on insn_o in cycle n+1.
- Redirect: redirect decided in cycle k gives a bubble in k+1 and the target instruction valid in k+2.
- Wrap-around: F=2^ADDR_W-1 increments to 0; branch/jump targets wrap the same way.
- pc_plus1_o = D+1, also modulo 2^ADDR_W.
- Self-loop: a branch to its own address is legal.
- Stall released in the same cycle as a taken redirect: the redirect is honoured.

Decomposition:
- Shared package holds:
  - ADDR_W default
  - RESET_PC default
  - state encoding: BOOT, RUN, HOLD, SQUASH (2-bit)
  - ROM latency constant (1)
- One combinational sub-module, next_pc_sel: computes taken and the target from the strobes, flags, D, imm_i, target_i and rd_val_i.

Test Plan:
- Reset release, ROM mem[i]=i, no strobes -> insn_valid_o=0 in the first cycle; then pc_o=0,1,2,3 on consecutive cycles with insn_o=mem[pc_o].
- bne_i=1, ne_i=1, imm_i=5 while pc_o=3 -> next cycle insn_valid_o=0; following cycle pc_o=9, valid. Repeat with ne_i=0 -> pc_o=4 with no bubble.
- stall_i held 3 cycles at pc_o=2 -> insn_o stays mem[2] and valid; after release pc_o=3 with insn_o=mem[3], no lost or duplicated instruction.
- jr_i=1, rd_val_i=0x0000_1FFF at ADDR_W=12 -> target 0xFFF; after the bubble, pc_o=0xFFF, then the next pc_o=0x000 (wrap).
- bex_i=1, target_i=100, rstatus_nz_i=0 -> no redirect; then rstatus_nz_i=1 -> bubble, then pc_o=100. Also drive j_i=1 with stall_i=1 -> ignored until stall_i drops.
- reset_n pulsed low mid-SQUASH -> outputs return to reset values asynchronously, before the next edge; fetch restarts at RESET_PC.
